array_4_arb: RTL and testbench

ARRAY_4_ARB -- requirements
Module: array_4_arb

---
 rtl/array_4_arb.sv | 134 +++++++++++++
 tb/tb_array_4_arb.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/array_4_arb.sv
// Two-requester round-robin front end for a single-port masked RAM.
// After reset the RAM is swept to INIT_VAL, then requests are arbitrated one per cycle.
module array_4_arb #(
  parameter logic [7:0] INIT_VAL = 8'h00
) (
  input  logic       clock,
  input  logic       reset_n,

  input  logic       a_req_valid,
  output logic       a_req_ready,
  input  logic       a_req_write,
  input  logic [7:0] a_req_addr,
  input  logic [7:0] a_req_mask,
  input  logic [7:0] a_req_data,
  output logic       a_resp_valid,
  output logic [7:0] a_resp_data,

  input  logic       b_req_valid,
  output logic       b_req_ready,
  input  logic       b_req_write,
  input  logic [7:0] b_req_addr,
  input  logic [7:0] b_req_mask,
  input  logic [7:0] b_req_data,
  output logic       b_resp_valid,
  output logic [7:0] b_resp_data,

  output logic       mem_en,
  output logic       mem_wmode,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wmask,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,

  output logic       init_busy,
  output logic [7:0] conflict_cnt
);

  typedef enum logic [1:0] {
    ST_PRE  = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] sweep_cnt;
  logic       ptr_b;      // 1 = B wins the next conflict
  logic       pend_a, pend_b;
  logic       in_run;
  logic       a_grant, b_grant;

  // Ready looks only at the other requester's valid, so no valid->ready loop exists.
  assign in_run      = (state == ST_RUN);
  assign a_req_ready = in_run && (!b_req_valid || !ptr_b);
  assign b_req_ready = in_run && (!a_req_valid ||  ptr_b);
  assign a_grant     = a_req_valid && a_req_ready;
  assign b_grant     = b_req_valid && b_req_ready;

  assign a_resp_valid = pend_a;
  assign b_resp_valid = pend_b;
  assign a_resp_data  = pend_a ? mem_rdata : 8'h00;
  assign b_resp_data  = pend_b ? mem_rdata : 8'h00;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_PRE;
    else          state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    state_nxt = state;
    init_busy = 1'b1;
    mem_en    = 1'b0;
    mem_wmode = 1'b0;
    mem_addr  = 8'h00;
    mem_wmask = 8'h00;
    mem_wdata = 8'h00;
    case (state)
      ST_PRE: state_nxt = ST_INIT;
      ST_INIT: begin
        mem_en    = 1'b1;
        mem_wmode = 1'b1;
        mem_addr  = sweep_cnt;
        mem_wmask = 8'hFF;
        mem_wdata = INIT_VAL;
        if (sweep_cnt == 8'hFF) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        init_busy = 1'b0;
        if (a_grant) begin
          mem_en    = 1'b1;
          mem_wmode = a_req_write;
          mem_addr  = a_req_addr;
          mem_wmask = a_req_mask;
          mem_wdata = a_req_data;
        end else if (b_grant) begin
          mem_en    = 1'b1;
          mem_wmode = b_req_write;
          mem_addr  = b_req_addr;
          mem_wmask = b_req_mask;
          mem_wdata = b_req_data;
        end
      end
      default: state_nxt = ST_PRE;
    endcase
  end

  // Counter wraps 255 -> 0 as INIT ends, leaving it ready for the next sweep.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)               sweep_cnt <= 8'h00;
    else if (state == ST_INIT)  sweep_cnt <= sweep_cnt + 8'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_b  <= 1'b0;
      pend_a <= 1'b0;
      pend_b <= 1'b0;
    end else begin
      if (a_grant)      ptr_b <= 1'b1;
      else if (b_grant) ptr_b <= 1'b0;
      pend_a <= a_grant && !a_req_write;
      pend_b <= b_grant && !b_req_write;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      conflict_cnt <= 8'h00;
    else if (in_run && a_req_valid && b_req_valid && (conflict_cnt != 8'hFF))
      conflict_cnt <= conflict_cnt + 8'd1;
  end

endmodule

// File: tb/tb_array_4_arb.sv
// Bench for array_4_arb: behavioural RAM, cycle-level reference model, directed scenarios.
module tb_array_4_arb;

  localparam logic [7:0] INIT_VAL = 8'h5A;

  logic       clock, reset_n;
  logic       a_req_valid, a_req_ready, a_req_write, a_resp_valid;
  logic [7:0] a_req_addr, a_req_mask, a_req_data, a_resp_data;
  logic       b_req_valid, b_req_ready, b_req_write, b_resp_valid;
  logic [7:0] b_req_addr, b_req_mask, b_req_data, b_resp_data;
  logic       mem_en, mem_wmode, init_busy;
  logic [7:0] mem_addr, mem_wmask, mem_wdata, mem_rdata, conflict_cnt;

  array_4_arb #(.INIT_VAL(INIT_VAL)) dut (
    .clock(clock), .reset_n(reset_n),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_write(a_req_write),
    .a_req_addr(a_req_addr), .a_req_mask(a_req_mask), .a_req_data(a_req_data),
    .a_resp_valid(a_resp_valid), .a_resp_data(a_resp_data),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_write(b_req_write),
    .b_req_addr(b_req_addr), .b_req_mask(b_req_mask), .b_req_data(b_req_data),
    .b_resp_valid(b_resp_valid), .b_resp_data(b_resp_data),
    .mem_en(mem_en), .mem_wmode(mem_wmode), .mem_addr(mem_addr), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .init_busy(init_busy), .conflict_cnt(conflict_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Synchronous single-port RAM attached to the DUT's memory port.
  logic [7:0] ram [256];
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_wmode) ram[mem_addr] <= (ram[mem_addr] & ~mem_wmask) | (mem_wdata & mem_wmask);
      else           mem_rdata <= ram[mem_addr];
    end
  end

  // Reference model: cycles since reset release, whose turn it is, expected RAM image,
  // pending responses and conflict count.
  int         m_cyc = 0;
  logic       m_turn_b = 1'b0;
  int         m_cnt = 0;
  logic       m_pa = 1'b0, m_pb = 1'b0;
  logic [7:0] m_pad = 8'h00, m_pbd = 8'h00;
  logic [7:0] m_mem [256];

  always @(negedge clock) begin : compare
    logic       run, ga, gb, e_en, e_wm;
    logic [7:0] e_addr, e_mask, e_data;
    if (!reset_n) begin
      m_cyc = 0; m_turn_b = 1'b0; m_cnt = 0;
      m_pa = 1'b0; m_pb = 1'b0; m_pad = 8'h00; m_pbd = 8'h00;
    end
    run = reset_n && (m_cyc >= 257);
    ga  = run && a_req_valid && (!b_req_valid || !m_turn_b);
    gb  = run && b_req_valid && (!a_req_valid ||  m_turn_b);
    e_en = 1'b0; e_wm = 1'b0; e_addr = 8'h00; e_mask = 8'h00; e_data = 8'h00;
    if (reset_n && m_cyc >= 1 && m_cyc <= 256) begin
      e_en = 1'b1; e_wm = 1'b1; e_addr = 8'(m_cyc - 1); e_mask = 8'hFF; e_data = INIT_VAL;
    end else if (ga) begin
      e_en = 1'b1; e_wm = a_req_write; e_addr = a_req_addr; e_mask = a_req_mask; e_data = a_req_data;
    end else if (gb) begin
      e_en = 1'b1; e_wm = b_req_write; e_addr = b_req_addr; e_mask = b_req_mask; e_data = b_req_data;
    end

    check("init_busy",    init_busy,    !run);
    check("a_req_ready",  a_req_ready,  run && (!b_req_valid || !m_turn_b));
    check("b_req_ready",  b_req_ready,  run && (!a_req_valid ||  m_turn_b));
    check("mem_en",       mem_en,       e_en);
    check("mem_wmode",    mem_wmode,    e_wm);
    check("mem_addr",     mem_addr,     e_addr);
    check("mem_wmask",    mem_wmask,    e_mask);
    check("mem_wdata",    mem_wdata,    e_data);
    check("a_resp_valid", a_resp_valid, m_pa);
    check("a_resp_data",  a_resp_data,  m_pa ? m_pad : 8'h00);
    check("b_resp_valid", b_resp_valid, m_pb);
    check("b_resp_data",  b_resp_data,  m_pb ? m_pbd : 8'h00);
    check("conflict_cnt", conflict_cnt, m_cnt);

    if (reset_n) begin
      if (m_cyc >= 1 && m_cyc <= 256) m_mem[m_cyc - 1] = INIT_VAL;
      m_pa  = ga && !a_req_write;
      m_pb  = gb && !b_req_write;
      m_pad = m_mem[a_req_addr];
      m_pbd = m_mem[b_req_addr];
      if (ga && a_req_write)
        m_mem[a_req_addr] = (m_mem[a_req_addr] & ~a_req_mask) | (a_req_data & a_req_mask);
      if (gb && b_req_write)
        m_mem[b_req_addr] = (m_mem[b_req_addr] & ~b_req_mask) | (b_req_data & b_req_mask);
      if (ga)      m_turn_b = 1'b1;
      else if (gb) m_turn_b = 1'b0;
      if (run && a_req_valid && b_req_valid && m_cnt < 255) m_cnt++;
      if (m_cyc < 1000) m_cyc++;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = 8'h00; a_req_mask = 8'h00; a_req_data = 8'h00;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = 8'h00; b_req_mask = 8'h00; b_req_data = 8'h00;
  endtask

  task automatic drive_a(input logic wr, input logic [7:0] addr, input logic [7:0] mask, input logic [7:0] data);
    a_req_valid = 1'b1; a_req_write = wr; a_req_addr = addr; a_req_mask = mask; a_req_data = data;
  endtask

  task automatic drive_b(input logic wr, input logic [7:0] addr, input logic [7:0] mask, input logic [7:0] data);
    b_req_valid = 1'b1; b_req_write = wr; b_req_addr = addr; b_req_mask = mask; b_req_data = data;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] stream_exp [3];
    stream_exp[0] = 8'hAF; stream_exp[1] = 8'h5A; stream_exp[2] = 8'h5A;
    reset_n = 1'b0;
    idle();
    #1;
    check("rst_busy", init_busy, 1'b1);
    check("rst_mem_en", mem_en, 1'b0);
    check("rst_conflict", conflict_cnt, 8'h00);
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    #1;
    check("pre_busy", init_busy, 1'b1);
    check("pre_mem_en", mem_en, 1'b0);
    check("pre_a_ready", a_req_ready, 1'b0);

    // Init sweep: 256 writes of INIT_VAL, addresses 0..255.
    step();
    check("init_first_addr", mem_addr, 8'h00);
    check("init_first_data", mem_wdata, 8'h5A);
    check("init_first_mask", mem_wmask, 8'hFF);
    repeat (255) step();
    check("init_last_addr", mem_addr, 8'hFF);
    check("init_last_busy", init_busy, 1'b1);
    step();
    check("run_busy", init_busy, 1'b0);
    check("run_a_ready", a_req_ready, 1'b1);

    // Any address reads back the init value.
    drive_a(1'b0, 8'h37, 8'h00, 8'h00);
    step(); idle(); #1;
    check("init_read_valid", a_resp_valid, 1'b1);
    check("init_read_data", a_resp_data, 8'h5A);

    // A write then immediate read of the same address.
    drive_a(1'b1, 8'h10, 8'hFF, 8'hA5);
    step();
    drive_a(1'b0, 8'h10, 8'h00, 8'h00);
    step(); idle(); #1;
    check("a_rd_valid", a_resp_valid, 1'b1);
    check("a_rd_data", a_resp_data, 8'hA5);
    check("a_rd_b_quiet", b_resp_valid, 1'b0);

    // Zero-mask write is issued but leaves the word unchanged.
    drive_a(1'b1, 8'h10, 8'h00, 8'h00);
    #1;
    check("mask0_issued", mem_en, 1'b1);
    step();
    drive_a(1'b0, 8'h10, 8'h00, 8'h00);
    step(); idle(); #1;
    check("mask0_data", a_resp_data, 8'hA5);

    // B partial write then read.
    drive_b(1'b1, 8'h10, 8'h0F, 8'hFF);
    step();
    drive_b(1'b0, 8'h10, 8'h00, 8'h00);
    step(); idle(); #1;
    check("b_rd_valid", b_resp_valid, 1'b1);
    check("b_rd_data", b_resp_data, 8'hAF);
    check("b_rd_a_quiet", a_resp_valid, 1'b0);

    // Last grant went to B, so A is favoured: both valid -> A,B,A,B.
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b0, 8'(i), 8'h00, 8'h00);
      drive_b(1'b0, 8'(8'h20 + i), 8'h00, 8'h00);
      #1;
      check("rr_a_grant", a_req_ready, (i % 2) == 0);
      check("rr_b_grant", b_req_ready, (i % 2) == 1);
      step();
    end
    idle(); #1;
    check("conflict_4", conflict_cnt, 8'h04);
    drive_a(1'b0, 8'h01, 8'h00, 8'h00);
    drive_b(1'b0, 8'h02, 8'h00, 8'h00);
    repeat (300) step();
    idle(); #1;
    check("conflict_sat", conflict_cnt, 8'hFF);
    step();

    // A idle, B streams reads back to back.
    for (int i = 0; i < 3; i++) begin
      drive_b(1'b0, 8'(8'h10 + i), 8'h00, 8'h00);
      #1;
      check("stream_b_ready", b_req_ready, 1'b1);
      step();
      check("stream_b_valid", b_resp_valid, 1'b1);
      check("stream_b_data", b_resp_data, stream_exp[i]);
    end
    idle();
    step();

    // Reset right after an A read is accepted: the response must be dropped.
    drive_a(1'b0, 8'h10, 8'h00, 8'h00);
    @(posedge clock);
    #1 reset_n = 1'b0;
    idle();
    #1;
    check("rst_drop_valid", a_resp_valid, 1'b0);
    check("rst_drop_busy", init_busy, 1'b1);
    check("rst_drop_cnt", conflict_cnt, 8'h00);
    repeat (2) step();
    reset_n = 1'b1;
    #1;
    check("rel_valid", a_resp_valid, 1'b0);
    check("rel_busy", init_busy, 1'b1);
    step();
    check("resweep_en", mem_en, 1'b1);
    check("resweep_addr", mem_addr, 8'h00);
    check("resweep_valid", a_resp_valid, 1'b0);
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
